// File: rtl/gf180mcu_osu_sc_cell_bist_pkg.sv
// Shared definitions for the 4-input AOI31/OAI31 cell BIST.
//   - bist_state_e : controller states (IDLE, SETTLE, CAPTURE, DONE)
//   - FUNC_AOI31 / FUNC_OAI31 : golden-model selectors
//   - MISR_POLY / MISR_SEED   : signature register polynomial taps and seed
//   - exp_val(func, vec)      : expected cell output for vec = {B,A2,A1,A0}
package gf180mcu_osu_sc_cell_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } bist_state_e;

    localparam int FUNC_AOI31 = 0;
    localparam int FUNC_OAI31 = 1;

    // x^16 + x^12 + x^5 + 1 : the x^16 term is implied by the shift-out.
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic exp_val(input int func, input logic [3:0] vec);
        logic a0, a1, a2, b;
        {b, a2, a1, a0} = vec;
        if (func == FUNC_OAI31) begin
            return ~((a0 | a1 | a2) & b);
        end
        return ~((a0 & a1 & a2) | b);
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_cell_bist_misr.sv
// 16-bit serial-input signature register for the cell BIST.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (signature clears to 0)
//   load       : load MISR_SEED (takes priority over en)
//   en         : shift din into the signature this cycle
//   din        : serial data (sampled cell response)
//   sig        : current signature
module gf180mcu_osu_sc_cell_bist_misr
    import gf180mcu_osu_sc_cell_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] sig_q, sig_d;
    logic        fb;

    always_comb begin
        sig_d = sig_q;
        fb    = sig_q[15] ^ din;
        if (load) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/gf180mcu_osu_sc_9t_cell_bist.sv
// Exhaustive BIST driver/checker for a 4-input AOI31/OAI31 cell.
// Sweeps all 16 input vectors NUM_PASSES times, holding each vector for
// SETTLE_CYCLES cycles before sampling the cell output in a one-cycle CAPTURE
// and comparing it with the built-in golden model.
// Optional feature: define GF180_CELL_BIST_MISR_EN to compact every captured
// response into a 16-bit MISR; otherwise signature is tied to 0.
// Ports:
//   CLK, RN        : clock (rising edge), asynchronous active-low reset
//   start          : single-cycle run request, ignored while busy
//   stim           : {B,A2,A1,A0} driven to the cell under test
//   resp           : cell output Y
//   busy / done    : run in progress / run complete (held until next start)
//   pass           : valid with done, 1 = no mismatches
//   err_cnt        : saturating mismatch count
//   fail_valid     : at least one mismatch this run
//   first_fail_vec : stim value of the first mismatch
//   signature      : MISR signature
module gf180mcu_osu_sc_9t_cell_bist
    import gf180mcu_osu_sc_cell_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int NUM_PASSES    = 1,
    parameter int FUNC          = FUNC_AOI31
) (
    input  logic        CLK,
    input  logic        RN,
    input  logic        start,
    output logic [3:0]  stim,
    input  logic        resp,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic        fail_valid,
    output logic [3:0]  first_fail_vec,
    output logic [15:0] signature
);

    localparam int SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    // With no settle time the controller goes straight from vector to vector.
    localparam bist_state_e VEC_STATE = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;

    bist_state_e   state_q, state_d;
    logic [3:0]    vec_q, vec_d;
    logic [7:0]    pass_cnt_q, pass_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          fail_valid_q, fail_valid_d;
    logic [3:0]    first_fail_vec_q, first_fail_vec_d;
    logic          start_accept;
    logic          capture;
    logic          mismatch;

    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign capture      = (state_q == S_CAPTURE);
    assign mismatch     = capture && (resp != exp_val(FUNC, vec_q));

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        vec_d            = vec_q;
        pass_cnt_d       = pass_cnt_q;
        settle_cnt_d     = settle_cnt_q;
        err_cnt_d        = err_cnt_q;
        fail_valid_d     = fail_valid_q;
        first_fail_vec_d = first_fail_vec_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_accept) begin
                    state_d          = VEC_STATE;
                    vec_d            = 4'h0;
                    pass_cnt_d       = 8'd0;
                    settle_cnt_d     = '0;
                    err_cnt_d        = 8'd0;
                    fail_valid_d     = 1'b0;
                    first_fail_vec_d = 4'h0;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_LAST)) begin
                    settle_cnt_d = '0;
                    state_d      = S_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            S_CAPTURE: begin
                if (mismatch) begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d     = 1'b1;
                        first_fail_vec_d = vec_q;
                    end
                end
                if (vec_q == 4'hF) begin
                    if (pass_cnt_q == 8'(NUM_PASSES - 1)) begin
                        // Last vector of the last pass: stim stays at 4'hF.
                        state_d = S_DONE;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        vec_d      = 4'h0;
                        state_d    = VEC_STATE;
                    end
                end else begin
                    vec_d   = vec_q + 4'd1;
                    state_d = VEC_STATE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q          <= S_IDLE;
            vec_q            <= 4'h0;
            pass_cnt_q       <= 8'd0;
            settle_cnt_q     <= '0;
            err_cnt_q        <= 8'd0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= 4'h0;
        end else begin
            state_q          <= state_d;
            vec_q            <= vec_d;
            pass_cnt_q       <= pass_cnt_d;
            settle_cnt_q     <= settle_cnt_d;
            err_cnt_q        <= err_cnt_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign stim           = vec_q;
    assign busy           = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done           = (state_q == S_DONE);
    assign pass           = done && !fail_valid_q;
    assign err_cnt        = err_cnt_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_vec_q;

`ifdef GF180_CELL_BIST_MISR_EN
    gf180mcu_osu_sc_cell_bist_misr u_misr (
        .clk   (CLK),
        .rst_n (RN),
        .load  (start_accept),
        .en    (capture),
        .din   (resp),
        .sig   (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_cell_bist.sv
// Self-checking bench for gf180mcu_osu_sc_9t_cell_bist.
// Three instances with different settle/pass/function settings. Each cell
// response is a behavioural AOI31/OAI31 gate, optionally corrupted by a random
// per-vector fault mask or replaced by a stuck value. Expected results come
// from a sweep-level model of the run.
module tb_gf180mcu_osu_sc_9t_cell_bist;

    localparam int D0_FUNC = 0, D0_SETTLE = 3, D0_PASSES = 1;
    localparam int D1_FUNC = 1, D1_SETTLE = 0, D1_PASSES = 2;
    localparam int D2_FUNC = 0, D2_SETTLE = 1, D2_PASSES = 32;

    // Response modes
    localparam int M_GOLD   = 0;  // own golden function XOR fault mask
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_OTHER  = 3;  // the other function's golden output

    logic        CLK = 1'b0;
    logic        RN;
    logic        start_r    [3];
    logic [3:0]  stim_w     [3];
    logic        resp_w     [3];
    logic        busy_w     [3];
    logic        done_w     [3];
    logic        pass_w     [3];
    logic [7:0]  err_w      [3];
    logic        fv_w       [3];
    logic [3:0]  ffv_w      [3];
    logic [15:0] sig_w      [3];
    int          mode_r     [3];
    logic [15:0] mask_r     [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    function automatic logic gate(input int func, input logic [3:0] v);
        if (func == 1) return !((v[0] || v[1] || v[2]) && v[3]);
        return !((v[0] && v[1] && v[2]) || v[3]);
    endfunction

    function automatic logic resp_of(input int mode, input int func,
                                     input logic [15:0] mask, input logic [3:0] v);
        case (mode)
            M_STUCK0: return 1'b0;
            M_STUCK1: return 1'b1;
            M_OTHER:  return gate(1 - func, v);
            default:  return gate(func, v) ^ mask[v];
        endcase
    endfunction

    assign resp_w[0] = resp_of(mode_r[0], D0_FUNC, mask_r[0], stim_w[0]);
    assign resp_w[1] = resp_of(mode_r[1], D1_FUNC, mask_r[1], stim_w[1]);
    assign resp_w[2] = resp_of(mode_r[2], D2_FUNC, mask_r[2], stim_w[2]);

    gf180mcu_osu_sc_9t_cell_bist #(.SETTLE_CYCLES(D0_SETTLE), .NUM_PASSES(D0_PASSES), .FUNC(D0_FUNC)) dut0 (
        .CLK(CLK), .RN(RN), .start(start_r[0]), .stim(stim_w[0]), .resp(resp_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
        .fail_valid(fv_w[0]), .first_fail_vec(ffv_w[0]), .signature(sig_w[0]));

    gf180mcu_osu_sc_9t_cell_bist #(.SETTLE_CYCLES(D1_SETTLE), .NUM_PASSES(D1_PASSES), .FUNC(D1_FUNC)) dut1 (
        .CLK(CLK), .RN(RN), .start(start_r[1]), .stim(stim_w[1]), .resp(resp_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
        .fail_valid(fv_w[1]), .first_fail_vec(ffv_w[1]), .signature(sig_w[1]));

    gf180mcu_osu_sc_9t_cell_bist #(.SETTLE_CYCLES(D2_SETTLE), .NUM_PASSES(D2_PASSES), .FUNC(D2_FUNC)) dut2 (
        .CLK(CLK), .RN(RN), .start(start_r[2]), .stim(stim_w[2]), .resp(resp_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[2]),
        .fail_valid(fv_w[2]), .first_fail_vec(ffv_w[2]), .signature(sig_w[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int d, output int func, output int settle, output int passes);
        case (d)
            0:       begin func = D0_FUNC; settle = D0_SETTLE; passes = D0_PASSES; end
            1:       begin func = D1_FUNC; settle = D1_SETTLE; passes = D1_PASSES; end
            default: begin func = D2_FUNC; settle = D2_SETTLE; passes = D2_PASSES; end
        endcase
    endtask

    // Whole-run model: walk every vector of every pass in order.
    task automatic model(input int d, output logic [7:0] e_err, output logic e_fv,
                         output logic [3:0] e_ffv, output logic [15:0] e_sig);
        int func, settle, passes, mism;
        logic r;
        logic [3:0] v;
        cfg(d, func, settle, passes);
        mism  = 0;
        e_fv  = 1'b0;
        e_ffv = 4'h0;
        e_sig = 16'hFFFF;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 16; i++) begin
                v = 4'(i);
                r = resp_of(mode_r[d], func, mask_r[d], v);
                if (r != gate(func, v)) begin
                    if (!e_fv) e_ffv = v;
                    e_fv = 1'b1;
                    mism++;
                end
                // Signature as polynomial division of the response stream.
                e_sig = {e_sig[14:0], 1'b0} ^ ((e_sig[15] ^ r) ? 16'h1021 : 16'h0000);
            end
        end
        e_err = (mism > 255) ? 8'hFF : 8'(mism);
`ifndef GF180_CELL_BIST_MISR_EN
        e_sig = 16'h0000;
`endif
    endtask

    task automatic run(input int d, input string tag, input int restart_at);
        int func, settle, passes, cycles, budget;
        logic [7:0] e_err;
        logic e_fv;
        logic [3:0] e_ffv;
        logic [15:0] e_sig;
        cfg(d, func, settle, passes);
        model(d, e_err, e_fv, e_ffv, e_sig);
        budget = 16 * (settle + 1) * passes + 50;
        start_r[d] = 1'b1;
        @(posedge CLK);
        #1;
        start_r[d] = 1'b0;
        cycles = 1;
        check({tag, "_busy"}, 32'(busy_w[d]), 32'd1);
        while (!done_w[d] && cycles < budget) begin
            start_r[d] = (cycles == restart_at);
            @(posedge CLK);
            #1;
            cycles++;
        end
        start_r[d] = 1'b0;
        check({tag, "_len"},  32'(cycles), 32'(16 * (settle + 1) * passes + 1));
        check({tag, "_done"}, 32'(done_w[d]), 32'd1);
        check({tag, "_idle"}, 32'(busy_w[d]), 32'd0);
        check({tag, "_pass"}, 32'(pass_w[d]), 32'(!e_fv));
        check({tag, "_err"},  32'(err_w[d]), 32'(e_err));
        check({tag, "_fv"},   32'(fv_w[d]), 32'(e_fv));
        check({tag, "_ffv"},  32'(ffv_w[d]), 32'(e_ffv));
        check({tag, "_stim"}, 32'(stim_w[d]), 32'hF);
        check({tag, "_sig"},  32'(sig_w[d]), 32'(e_sig));
    endtask

    function automatic logic [31:0] outs(input int d);
        return {stim_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d],
                fv_w[d], ffv_w[d], sig_w[d]};
    endfunction

    initial begin
        int d, waited;
        RN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            mode_r[i]  = M_GOLD;
            mask_r[i]  = 16'h0000;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_d%0d", i), outs(i), 32'h0);
        @(negedge CLK);
        RN = 1'b1;
        @(posedge CLK);
        #1;

        // Golden loopback, stuck-at responses, saturation
        run(0, "gold", -1);
        mode_r[0] = M_STUCK0;  run(0, "stuck0", -1);
        mode_r[0] = M_STUCK1;  run(0, "stuck1", -1);
        mode_r[2] = M_STUCK1;  run(2, "sat", -1);

        // OAI31 golden, then OAI31 checker fed an AOI31 response
        mode_r[1] = M_GOLD;    run(1, "oai_gold", -1);
        mode_r[1] = M_OTHER;   run(1, "oai_vs_aoi", -1);

        // Random fault masks
        for (int k = 0; k < 8; k++) begin
            d = (k == 7) ? 2 : int'($urandom_range(0, 1));
            mode_r[d] = M_GOLD;
            mask_r[d] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            run(d, $sformatf("rand%0d_d%0d", k, d), -1);
        end
        mask_r[0] = 16'h0000;
        mask_r[2] = 16'h0000;

        // Start while busy is ignored
        mode_r[0] = M_GOLD;
        run(0, "restart", 10);

        // Reset mid-run at vec 5 with errors already counted
        mode_r[0]  = M_STUCK0;
        start_r[0] = 1'b1;
        @(posedge CLK);
        #1;
        start_r[0] = 1'b0;
        waited = 0;
        while (stim_w[0] != 4'h5 && waited < 200) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        check("rst_wait_vec", 32'(stim_w[0]), 32'h5);
        check("rst_pre_err", 32'(err_w[0]), 32'd5);
        RN = 1'b0;
        #1;
        check("rst_mid_outs", outs(0), 32'h0);
        @(negedge CLK);
        RN = 1'b1;
        @(posedge CLK);
        #1;
        mode_r[0] = M_GOLD;
        run(0, "after_rst", -1);

        // Signature repeatability
        run(0, "misr_a", -1);
        run(0, "misr_b", -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
